// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: issues imem requests, bounds in-flight fetches, squashes stale responses and
// drains on FENCE. Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect traps to TRAP_VEC).
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_fence,
  input  logic [31:0] i_fence_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  output logic        o_inst_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_predecessor,
  output logic [31:0] o_successor,
  output logic        o_busy,
  output logic        o_fence_done
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        o_misalign_err
`endif
);

  typedef enum logic [0:0] {StFetch, StDrain} state_e;

  localparam logic [2:0] MaxOutst = 3'(MAX_OUTST);

  state_e      r_state;
  logic [2:0]  r_outst;
  logic [2:0]  r_discard;
  logic [31:0] r_pc;
  logic [31:0] r_pred;
  logic [31:0] r_succ;
  logic        r_fence_done;

  logic        w_resp;
  logic        w_hs;
  logic        w_fence_take;
  logic [2:0]  w_outst_after_resp;
  logic [2:0]  w_outst_nxt;
  logic [31:0] w_redirect_tgt;
  logic        w_misalign;

  // A response only counts when something is actually in flight.
  assign w_resp             = i_imem_rvalid & (r_outst != 3'd0);
  assign o_imem_req         = ~i_reset & (r_state == StFetch) & ~i_stall & ~i_redirect_valid &
                              ~i_fence & (r_outst < MaxOutst);
  assign w_hs               = o_imem_req & i_imem_gnt;
  assign w_outst_after_resp = r_outst - {2'b00, w_resp};
  assign w_outst_nxt        = w_outst_after_resp + {2'b00, w_hs};
  assign w_fence_take       = i_fence & ~i_redirect_valid & (r_state == StFetch);

  assign o_inst_valid  = ~i_reset & w_resp & (r_discard == 3'd0);
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_predecessor = r_pred;
  assign o_successor   = r_succ;
  assign o_busy        = (r_state == StDrain);
  assign o_fence_done  = r_fence_done;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign_err;
  assign w_misalign     = |i_redirect_pc[1:0];
  assign w_redirect_tgt = w_misalign ? TRAP_VEC : i_redirect_pc;
  assign o_misalign_err = r_misalign_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_misalign_err <= 1'b0;
    else         r_misalign_err <= i_redirect_valid & w_misalign;
  end
`else
  assign w_misalign     = 1'b0;
  assign w_redirect_tgt = {i_redirect_pc[31:2], 2'b00};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StFetch;
      r_outst      <= 3'd0;
      r_discard    <= 3'd0;
      r_pc         <= RESET_VEC;
      r_pred       <= 32'h0;
      r_succ       <= 32'h0;
      r_fence_done <= 1'b0;
    end else begin
      r_outst      <= w_outst_nxt;
      r_fence_done <= 1'b0;

      // Everything still in flight after this cycle's response becomes stale.
      if (i_redirect_valid || w_fence_take) begin
        r_discard <= w_outst_after_resp;
      end else if (w_resp && (r_discard != 3'd0)) begin
        r_discard <= r_discard - 3'd1;
      end

      if (i_redirect_valid) begin
        r_pc <= w_redirect_tgt;
      end else if (w_fence_take) begin
        r_pc <= i_fence_pc + 32'd4;
      end else if (w_hs) begin
        r_pc <= r_pc + 32'd4;
      end

      case (r_state)
        StFetch: begin
          if (w_fence_take) begin
            r_pred  <= i_fence_pc;
            r_succ  <= i_fence_pc + 32'd4;
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_outst_nxt == 3'd0) begin
            r_state      <= StFetch;
            r_fence_done <= 1'b1;
          end
        end
        default: r_state <= StFetch;
      endcase
    end
  end

endmodule
